qbus_master: RTL and testbench

Synthesizable Q-bus master sequencer that drives the 1801VP1-033 serial-port device: it turns single-word commands (read, write, interrupt-acknowledge, bus init) into correctly phased nSYNC/nDIN/nDOUT/nWTBT/nIAKO/nINIT handshakes on the active-low multiplexed nAD bus. It is the stage directly upstream of the 033, on the processor/bus side, and turns the bench-level bus cycles into hardware. Results, including interrupt vectors and timeout errors, return on a response port.

---
 rtl/qbus_pkg.sv | 34 +++
 rtl/qbus_master_if.sv | 61 ++++++
 rtl/qbus_sync2.sv | 28 ++
 rtl/qbus_master.sv | 229 ++++++++++++++++++++++
 tb/tb_qbus_master.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/qbus_pkg.sv
// -----------------------------------------------------------------------------
// qbus_pkg
//   Shared definitions for the Q-bus master sequencer.
//   - qb_op_t   : command op encodings presented on cmd_op
//   - state_t   : sequencer FSM states (also exported as a debug signal)
//   - DEV_WIN   : address bits [15:13] that mark the I/O page (drives nBS)
// -----------------------------------------------------------------------------
package qbus_pkg;

    typedef enum logic [1:0] {
        QB_READ  = 2'd0,
        QB_WRITE = 2'd1,
        QB_IAK   = 2'd2,
        QB_INIT  = 2'd3
    } qb_op_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ADDR  = 4'd1,
        ST_SYNC  = 4'd2,
        ST_DATA  = 4'd3,
        ST_STRB  = 4'd4,
        ST_WREP  = 4'd5,
        ST_SAMP  = 4'd6,
        ST_REL   = 4'd7,
        ST_WNREP = 4'd8,
        ST_DONE  = 4'd9,
        ST_INIT  = 4'd10
    } state_t;

    // Top three address bits of the I/O page (160000-177777 octal).
    localparam logic [2:0] DEV_WIN = 3'b111;

endpackage

// File: rtl/qbus_master_if.sv
// -----------------------------------------------------------------------------
// qbus_master_if
//   Groups the command/response port and the Q-bus pins of qbus_master.
//
//   Command handshake: a command transfers on a rising clock edge where both
//   cmd_valid and cmd_ready are high. cmd_ready is high only while the
//   sequencer is idle; cmd_valid while cmd_ready is low is ignored (no
//   queuing). The response is a one-cycle rsp_valid pulse with rsp_data and
//   rsp_err; there is no rsp_ready, the consumer must take it when it appears.
//
//   Signals:
//     cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data  command request
//     rsp_valid/rsp_data/rsp_err                    completion response
//     irq                                           synchronized ~nVIRQ
//     nAD_out/nAD_oe/nAD_in                         multiplexed active-low bus
//     nBS..nINIT                                    active-low controls (out)
//     nRPLY/nVIRQ                                   async inputs from device
//     dbg_state                                     current FSM state
//   Modports: master (sequencer side), slave (device / stimulus side).
// -----------------------------------------------------------------------------
interface qbus_master_if;
    import qbus_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        irq;
    logic [15:0] nAD_out;
    logic        nAD_oe;
    logic [15:0] nAD_in;
    logic        nBS;
    logic        nSYNC;
    logic        nDIN;
    logic        nDOUT;
    logic        nWTBT;
    logic        nIAKO;
    logic        nINIT;
    logic        nRPLY;
    logic        nVIRQ;
    state_t      dbg_state;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, nAD_in, nRPLY, nVIRQ,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, irq,
        output nAD_out, nAD_oe, nBS, nSYNC, nDIN, nDOUT, nWTBT, nIAKO, nINIT,
        output dbg_state
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, nAD_in, nRPLY, nVIRQ,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, irq,
        input  nAD_out, nAD_oe, nBS, nSYNC, nDIN, nDOUT, nWTBT, nIAKO, nINIT,
        input  dbg_state
    );

endinterface

// File: rtl/qbus_sync2.sv
// -----------------------------------------------------------------------------
// qbus_sync2
//   Two-flop synchronizer for active-low asynchronous bus inputs. Resets to 1
//   so an undriven/idle line reads as deasserted.
//   Ports: clk_i, rst_ni (async active-low), d_i (async in), q_o (synced out)
// -----------------------------------------------------------------------------
module qbus_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q, s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/qbus_master.sv
// -----------------------------------------------------------------------------
// qbus_master
//   Q-bus master sequencer: turns single-word commands (READ, WRITE, IAK,
//   INIT) into phased nSYNC/nDIN/nDOUT/nWTBT/nIAKO/nINIT handshakes on the
//   multiplexed active-low nAD bus and returns read data / vectors / timeout
//   errors on the response port.
//   Ports:
//     PIN_CLK   system clock (rising edge)
//     PIN_nRST  asynchronous active-low reset
//     bus       qbus_master_if.master (command, response, Q-bus pins, debug)
//   Parameters: T_PH phase length, T_DAT reply-to-sample delay,
//               T_TMO reply timeout, T_INIT nINIT width (all in cycles).
// -----------------------------------------------------------------------------
module qbus_master
    import qbus_pkg::*;
#(
    parameter int T_PH   = 4,
    parameter int T_DAT  = 8,
    parameter int T_TMO  = 1023,
    parameter int T_INIT = 16
) (
    input  logic          PIN_CLK,
    input  logic          PIN_nRST,
    qbus_master_if.master bus
);

    localparam logic [9:0] PH_LAST   = 10'(T_PH - 1);
    localparam logic [9:0] DAT_LAST  = 10'(T_DAT - 1);
    localparam logic [9:0] TMO_LAST  = 10'(T_TMO);
    localparam logic [9:0] INIT_LAST = 10'(T_INIT - 1);

    logic rply_s, virq_s;

    qbus_sync2 u_sync_rply (.clk_i(PIN_CLK), .rst_ni(PIN_nRST), .d_i(bus.nRPLY), .q_o(rply_s));
    qbus_sync2 u_sync_virq (.clk_i(PIN_CLK), .rst_ni(PIN_nRST), .d_i(bus.nVIRQ), .q_o(virq_s));

    state_t      state_q;
    qb_op_t      op_q;
    logic [15:0] data_q;
    logic [9:0]  cnt_q;     // shared phase / sample / timeout counter
    logic        tail_q;    // second sub-phase of WNREP (write hold) and INIT (idle gap)
    logic        cmd_ready_q, rsp_valid_q, rsp_err_q;
    logic [15:0] rsp_data_q, nad_out_q;
    logic        nad_oe_q, nbs_q, nsync_q, ndin_q, ndout_q, nwtbt_q, niako_q, ninit_q;

    always_ff @(posedge PIN_CLK or negedge PIN_nRST) begin
        if (!PIN_nRST) begin
            state_q     <= ST_IDLE;
            op_q        <= QB_READ;
            data_q      <= '0;
            cnt_q       <= '0;
            tail_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            nad_out_q   <= '1;
            nad_oe_q    <= 1'b0;
            nbs_q       <= 1'b1;
            nsync_q     <= 1'b1;
            ndin_q      <= 1'b1;
            ndout_q     <= 1'b1;
            nwtbt_q     <= 1'b1;
            niako_q     <= 1'b1;
            ninit_q     <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!cmd_ready_q) begin
                        cmd_ready_q <= 1'b1;
                    end else if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= qb_op_t'(bus.cmd_op);
                        data_q      <= bus.cmd_data;
                        cnt_q       <= '0;
                        tail_q      <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        case (qb_op_t'(bus.cmd_op))
                            QB_READ, QB_WRITE: begin
                                state_q   <= ST_ADDR;
                                nad_oe_q  <= 1'b1;
                                nad_out_q <= ~bus.cmd_addr;
                                nbs_q     <= ~(bus.cmd_addr[15:13] == DEV_WIN);
                                nwtbt_q   <= (qb_op_t'(bus.cmd_op) != QB_WRITE);
                            end
                            QB_IAK: begin
                                // No address cycle; DATA gives the turnaround gap.
                                state_q  <= ST_DATA;
                                nad_oe_q <= 1'b0;
                            end
                            default: begin
                                state_q <= ST_INIT;
                                ninit_q <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (cnt_q == PH_LAST) begin
                        cnt_q   <= '0;
                        nsync_q <= 1'b0;
                        state_q <= ST_SYNC;
                    end else cnt_q <= cnt_q + 10'd1;
                end
                ST_SYNC: begin
                    if (cnt_q == PH_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_DATA;
                        if (op_q == QB_WRITE) begin
                            nad_out_q <= ~data_q;
                            nwtbt_q   <= 1'b1;
                        end else begin
                            // Release the bus a full phase before nDIN so the device can drive.
                            nad_oe_q <= 1'b0;
                        end
                    end else cnt_q <= cnt_q + 10'd1;
                end
                ST_DATA: begin
                    if (cnt_q == PH_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_STRB;
                        if (op_q == QB_WRITE) ndout_q <= 1'b0;
                        else                  ndin_q  <= 1'b0;
                        if (op_q == QB_IAK)   niako_q <= 1'b0;
                    end else cnt_q <= cnt_q + 10'd1;
                end
                ST_STRB: begin
                    cnt_q   <= '0;
                    state_q <= ST_WREP;
                end
                ST_WREP: begin
                    if (!rply_s || cnt_q == TMO_LAST) begin
                        if (rply_s) begin
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= '0;
                        end
                        cnt_q <= '0;
                        if (rply_s || op_q == QB_WRITE) begin
                            // Timeout or write reply: release strobes now.
                            state_q <= ST_REL;
                            nsync_q <= 1'b1;
                            ndin_q  <= 1'b1;
                            ndout_q <= 1'b1;
                            niako_q <= 1'b1;
                            nbs_q   <= 1'b1;
                        end else begin
                            state_q <= ST_SAMP;
                        end
                    end else cnt_q <= cnt_q + 10'd1;
                end
                ST_SAMP: begin
                    if (cnt_q == DAT_LAST) begin
                        rsp_data_q <= ~bus.nAD_in;
                        state_q    <= ST_REL;
                        nsync_q    <= 1'b1;
                        ndin_q     <= 1'b1;
                        ndout_q    <= 1'b1;
                        niako_q    <= 1'b1;
                        nbs_q      <= 1'b1;
                    end else cnt_q <= cnt_q + 10'd1;
                end
                ST_REL: begin
                    cnt_q   <= '0;
                    tail_q  <= 1'b0;
                    state_q <= ST_WNREP;
                end
                ST_WNREP: begin
                    if (tail_q) begin
                        // Write data held one more phase after the device let go of nRPLY.
                        if (cnt_q == PH_LAST) begin
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                            nad_oe_q    <= 1'b0;
                            nad_out_q   <= '1;
                        end else cnt_q <= cnt_q + 10'd1;
                    end else if (rply_s && op_q == QB_WRITE) begin
                        tail_q <= 1'b1;
                        cnt_q  <= '0;
                    end else if (rply_s || cnt_q == TMO_LAST) begin
                        if (!rply_s) begin
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= '0;
                        end
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                        nad_oe_q    <= 1'b0;
                        nad_out_q   <= '1;
                    end else cnt_q <= cnt_q + 10'd1;
                end
                ST_DONE: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                ST_INIT: begin
                    if (!tail_q) begin
                        if (cnt_q == INIT_LAST) begin
                            ninit_q <= 1'b1;
                            tail_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else cnt_q <= cnt_q + 10'd1;
                    end else if (cnt_q == PH_LAST) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                    end else cnt_q <= cnt_q + 10'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.irq       = ~virq_s;
    assign bus.nAD_out   = nad_out_q;
    assign bus.nAD_oe    = nad_oe_q;
    assign bus.nBS       = nbs_q;
    assign bus.nSYNC     = nsync_q;
    assign bus.nDIN      = ndin_q;
    assign bus.nDOUT     = ndout_q;
    assign bus.nWTBT     = nwtbt_q;
    assign bus.nIAKO     = niako_q;
    assign bus.nINIT     = ninit_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_qbus_master.sv
module tb_qbus_master;
  import qbus_pkg::*;

  localparam int T_PH   = 4;
  localparam int T_DAT  = 8;
  localparam int T_TMO  = 1023;
  localparam int T_INIT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  qbus_master_if bus ();

  qbus_master #(.T_PH(T_PH), .T_DAT(T_DAT), .T_TMO(T_TMO), .T_INIT(T_INIT)) dut (
    .PIN_CLK (clk),
    .PIN_nRST(rst_n),
    .bus     (bus)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- 033-like device model ----------------
  logic        dev_oe, dev_busy, dev_sel, dev_ie, dev_pend, dev_rply_n, prev_sync;
  logic [15:0] dev_out;
  logic [1:0]  dev_idx;
  logic [15:0] dev_mem [4];
  wire  [15:0] nad_bus = bus.nAD_oe ? bus.nAD_out : (dev_oe ? dev_out : 16'hFFFF);
  wire  [15:0] bus_val = ~nad_bus;
  wire  [15:0] dev_rd  = (dev_idx == 2'd2) ? (16'o000200 | {9'd0, dev_ie, 6'd0}) : dev_mem[dev_idx];

  assign bus.nAD_in = nad_bus;
  assign bus.nRPLY  = dev_rply_n;
  assign bus.nVIRQ  = ~dev_pend;

  always @(posedge clk) begin
    if (!dev_rst_n || bus.nINIT === 1'b0) begin
      dev_oe <= 1'b0; dev_busy <= 1'b0; dev_sel <= 1'b0; dev_ie <= 1'b0; dev_pend <= 1'b0;
      dev_rply_n <= 1'b1; prev_sync <= 1'b1; dev_out <= 16'hFFFF; dev_idx <= 2'd0;
    end else begin
      prev_sync <= bus.nSYNC;
      if (prev_sync && !bus.nSYNC) begin
        dev_idx <= bus_val[2:1];
        dev_sel <= !bus.nBS && ((bus_val & 16'o177770) == 16'o177560);
      end else if (bus.nSYNC) dev_sel <= 1'b0;
      if (dev_busy) begin
        if (bus.nDIN && bus.nDOUT) begin
          dev_busy <= 1'b0; dev_oe <= 1'b0; dev_rply_n <= 1'b1;
        end
      end else if (!bus.nIAKO && !bus.nDIN && dev_pend) begin
        dev_busy <= 1'b1; dev_oe <= 1'b1; dev_out <= ~16'o000064; dev_rply_n <= 1'b0; dev_pend <= 1'b0;
      end else if (dev_sel && !bus.nSYNC && !bus.nDIN) begin
        dev_busy <= 1'b1; dev_oe <= 1'b1; dev_out <= ~dev_rd; dev_rply_n <= 1'b0;
      end else if (dev_sel && !bus.nSYNC && !bus.nDOUT) begin
        dev_busy <= 1'b1; dev_rply_n <= 1'b0;
        if (dev_idx == 2'd2) begin
          dev_ie <= bus_val[6];
          if (bus_val[6] && !dev_ie) dev_pend <= 1'b1;
        end else dev_mem[dev_idx] <= bus_val;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [16:0] exp_q[$];
  int rsp_cnt = 0, acc_cyc = 0, last_lat = 0;
  int conflict = 0, init_sync_ovl = 0, ready_in_init = 0;
  int init_w = 0, init_last_w = 0, oe_low = 0, virq_fall_cyc = 0;
  logic addr_nbs = 1'b1, addr_wtbt = 1'b1;
  logic p_ndin = 1'b1, p_niako = 1'b1, p_ninit = 1'b1, p_virq = 1'b1, p_irq = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.nAD_oe && dev_oe) conflict++;
      if (!bus.nINIT && !bus.nSYNC) init_sync_ovl++;
      if (!bus.nINIT && bus.cmd_ready) ready_in_init++;
      if (bus.dbg_state == ST_ADDR) begin
        addr_nbs  = bus.nBS;
        addr_wtbt = bus.nWTBT;
      end
      if (!bus.nINIT) init_w++;
      else if (!p_ninit) begin init_last_w = init_w; init_w = 0; end
      if (p_ndin && !bus.nDIN) check("oe_before_din", (oe_low >= T_PH), 1);
      oe_low = bus.nAD_oe ? 0 : oe_low + 1;
      if (p_niako && !bus.nIAKO) check("iak_din_together", bus.nDIN, 1'b0);
      if (p_virq && !bus.nVIRQ) virq_fall_cyc = cyc;
      if (!p_irq && bus.irq) check("irq_lag", cyc - virq_fall_cyc, 2);
      if (bus.rsp_valid) begin
        rsp_cnt++;
        last_lat = cyc - acc_cyc;
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rsp", {bus.rsp_err, bus.rsp_data}, exp_q.pop_front());
      end
    end
    p_ndin = bus.nDIN; p_niako = bus.nIAKO; p_ninit = bus.nINIT;
    p_virq = bus.nVIRQ; p_irq = bus.irq;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
    int w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    if (bus.cmd_ready !== 1'b1) check("cmd_ready_wait", 0, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_rsp(input int n0);
    int w = 0;
    while (rsp_cnt == n0 && w < 3000) begin @(negedge clk); w++; end
    if (rsp_cnt == n0) check("rsp_wait_timeout", 0, 1);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data,
                        input logic [16:0] exp);
    int n0 = rsp_cnt;
    exp_q.push_back(exp);
    send(op, addr, data);
    wait_rsp(n0);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    logic [15:0] r0, r3;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = 16'd0; bus.cmd_data = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 16'h0000);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_nad_oe", bus.nAD_oe, 1'b0);
    check("rst_nad_out", bus.nAD_out, 16'hFFFF);
    check("rst_ctl", {bus.nBS, bus.nSYNC, bus.nDIN, bus.nDOUT, bus.nWTBT, bus.nIAKO, bus.nINIT}, 7'h7F);
    check("rst_irq", bus.irq, 1'b0);
    dev_rst_n = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // INIT
    n0 = rsp_cnt;
    do_cmd(2'(QB_INIT), 16'd0, 16'd0, 17'h00000);
    check("init_width", init_last_w, T_INIT);
    check("init_ready_low", ready_in_init, 0);
    check("init_one_rsp", rsp_cnt - n0, 1);

    // READ TX CSR after INIT
    do_cmd(2'(QB_READ), 16'o177564, 16'd0, {1'b0, 16'o000200});
    check("read_nbs_addr", addr_nbs, 1'b0);
    check("read_wtbt_addr", addr_wtbt, 1'b1);

    // WRITE interrupt enable, then read back
    do_cmd(2'(QB_WRITE), 16'o177564, 16'o000100, 17'h00000);
    check("write_wtbt_addr", addr_wtbt, 1'b0);
    do_cmd(2'(QB_READ), 16'o177564, 16'd0, {1'b0, 16'o000300});
    check("irq_set", bus.irq, 1'b1);

    // IAK returns the TX vector and clears the request
    do_cmd(2'(QB_IAK), 16'd0, 16'd0, {1'b0, 16'o000064});
    repeat (5) @(negedge clk);
    check("irq_cleared", bus.irq, 1'b0);

    // Plain storage registers with random data
    for (int i = 0; i < 3; i++) begin
      r0 = 16'($urandom_range(0, 16'hFFFF));
      r3 = 16'($urandom_range(0, 16'hFFFF));
      do_cmd(2'(QB_WRITE), 16'o177560, r0, 17'h00000);
      do_cmd(2'(QB_WRITE), 16'o177566, r3, 17'h00000);
      do_cmd(2'(QB_READ), 16'o177560, 16'd0, {1'b0, r0});
      do_cmd(2'(QB_READ), 16'o177566, 16'd0, {1'b0, r3});
    end

    // READ with no device -> timeout
    do_cmd(2'(QB_READ), 16'o160000, 16'd0, {1'b1, 16'h0000});
    check("tmo_latency_range", (last_lat >= T_TMO) && (last_lat <= T_TMO + 3 * T_PH + 12), 1);
    check("tmo_strobes_high", {bus.nBS, bus.nSYNC, bus.nDIN, bus.nDOUT, bus.nWTBT, bus.nIAKO}, 6'h3F);
    check("tmo_nad_oe", bus.nAD_oe, 1'b0);

    // Reset while a WRITE sits in WREP
    n0 = rsp_cnt;
    send(2'(QB_WRITE), 16'o160000, 16'h1234);
    begin
      int w = 0;
      while (bus.dbg_state != ST_WREP && w < 200) begin @(negedge clk); w++; end
    end
    check("reach_wrep", bus.dbg_state == ST_WREP, 1);
    check("wrep_ndout_low", bus.nDOUT, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", {bus.nDOUT, bus.nSYNC, bus.nWTBT, bus.nAD_oe}, 4'b1110);
    check("rst_mid_ready", bus.cmd_ready, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_rsp", rsp_cnt - n0, 0);

    // Next command completes normally (IE still set in the device)
    do_cmd(2'(QB_READ), 16'o177564, 16'd0, {1'b0, 16'o000300});

    check("exp_q_empty", exp_q.size(), 0);
    check("bus_conflict", conflict, 0);
    check("init_sync_overlap", init_sync_ovl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
